alu: RTL and testbench
======================

# alu

64-bit integer arithmetic/logic unit for the RV64 datapath, sitting in the execute stage between the operand muxes and the EX/MEM boundary. It computes one of the supported operations on two 64-bit operands, selected by a 4-bit `ALUop` from ALU control. The result is produced combinationally for same-cycle forwarding and branch resolution. A registered copy of the result and flags is also provided for the pipeline register.

## Interface
- No parameters; the datapath width is fixed at 64.
- `clk`  input  1  — single clock; the registered outputs update on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `A`  input  64  — operand A (rs1).
- `B`  input  64  — operand B (rs2 or immediate).
- `ALUop`  input  4  — operation select.
- `result`  output  64  — combinational result.
- `zero`  output  1  — combinational; 1 when `result` is all zeros.
- `overflow`  output  1  — combinational signed overflow for ADD/SUB; 0 for all other ops.
- `result_q`  output  64  — `result` registered on `clk`.
- `zero_q`  output  1  — `zero` registered on `clk`.
- `overflow_q`  output  1  — `overflow` registered on `clk`.

## Operation
`ALUop` encoding:
- 0000 AND: `A & B`.
- 0001 OR: `A | B`.
- 0010 ADD: `A + B`, modulo 2^64.
- 0011 XOR: `A ^ B`.
- 0100 SLL: `A << B[5:0]`.
- 0101 SRL: `A >> B[5:0]`, logical (zero fill).
- 0110 SUB: `A - B`, modulo 2^64.
- 0111 SLT: 64'd1 if signed(A) < signed(B), else 64'd0.
- 1000 SLTU: 64'd1 if unsigned A < unsigned B, else 64'd0.
- 1001 SRA: arithmetic right shift of A by `B[5:0]` (sign fill).
- 1100 NOR: `~(A | B)`.
- All other codes: `result` = 0, `overflow` = 0; no error is raised.

Rules:
- Shifts use only `B[5:0]`; `B[63:6]` is ignored. A shift by 0 returns A unchanged.
- SLT must be a true signed compare. It must not be derived from the sign of A−B without overflow correction (e.g. A = 0x8000…0, B = 1 gives 1).
- ADD overflow is `(A[63]==B[63]) && (result[63]!=A[63])`.
- SUB overflow is `(A[63]!=B[63]) && (result[63]!=A[63])`.
- `zero` is a reduction NOR of `result` for every op, including undefined ones (undefined op gives `zero` = 1).
- No carry-out is exported.

## Timing
- `result`, `zero` and `overflow` are purely combinational from `A`, `B` and `ALUop`, with zero-cycle latency, and are independent of `clk` and `rst`.
- `result_q`, `zero_q` and `overflow_q` capture the combinational values on every rising `clk`, giving 1-cycle latency. There is no enable and no handshake.
- While `rst` = 1, the registered outputs are forced immediately (asynchronously) to `result_q` = 0, `zero_q` = 1, `overflow_q` = 0.
- On `rst` deassertion, the first rising edge loads the live values.
- Asserting reset mid-stream discards the captured value at once; the combinational outputs are unaffected.
- Input changes between edges affect only the combinational outputs until the next edge.

## Test plan
- Logic ops: A = F0F0F0F0F0F0F0F0, B = 0F0F0F0F0F0F0F0F.
  - AND -> 0, `zero` = 1.
  - OR -> FFFFFFFFFFFFFFFF.
  - XOR -> FFFFFFFFFFFFFFFF.
  - NOR -> 0.
- Arithmetic:
  - ADD 123 + 456 -> 579.
  - SUB 1000 − 1 -> 999.
  - ADD 7FFFFFFFFFFFFFFF + 1 -> 8000000000000000, `overflow` = 1.
  - SUB 5 − 5 -> 0, `zero` = 1, `overflow` = 0.
- Compares:
  - SLT −5 vs 3 -> 1.
  - SLT 3 vs −5 -> 0.
  - SLTU FFFFFFFFFFFFFFFB vs 3 -> 0.
  - SLT 8000000000000000 vs 1 -> 1.
- Shifts, A = 8000000000000001:
  - SLL by B = 0x41 (uses 1) -> 0000000000000002.
  - SRL by 63 -> 1.
  - SRA by 63 -> FFFFFFFFFFFFFFFF.
  - Shift by 0 -> A.
- Undefined op: ALUop = 1111 -> `result` = 0, `zero` = 1, `overflow` = 0.
- Registered path:
  - Assert `rst` asynchronously mid-cycle -> `result_q` = 0, `zero_q` = 1 immediately.
  - Release `rst`, apply ADD 2 + 3 -> `result_q` = 5 after the next rising edge, not before.
  - Change inputs between edges -> `result_q` holds its previous value.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage operand muxes and the ALU.
interface alu_if;
  logic        [63:0] A;
  logic        [63:0] B;
  logic        [3:0]  ALUop;
  logic        [63:0] result;
  logic               zero;
  logic               overflow;
  logic        [63:0] result_q;
  logic               zero_q;
  logic               overflow_q;

  modport master (
    output A, B, ALUop,
    input  result, zero, overflow, result_q, zero_q, overflow_q
  );

  modport slave (
    input  A, B, ALUop,
    output result, zero, overflow, result_q, zero_q, overflow_q
  );
endinterface

// File: rtl/alu.sv
// RV64 execute-stage ALU: combinational result/flags for forwarding and
// branch resolution, plus a registered copy for the EX/MEM boundary.
module alu (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  // Signed overflow of a sum: operands agree in sign, result disagrees.
  function automatic logic ovf_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input logic signed [63:0] r);
    return (a[63] == b[63]) && (r[63] != a[63]);
  endfunction

  // Signed overflow of a difference: operands differ in sign, result
  // takes the sign of the subtrahend.
  function automatic logic ovf_sub(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input logic signed [63:0] r);
    return (a[63] != b[63]) && (r[63] != a[63]);
  endfunction

  logic signed [63:0] a_s;
  logic signed [63:0] b_s;
  logic        [5:0]  shamt;
  logic signed [63:0] sum_p0;
  logic signed [63:0] diff_p0;
  logic signed [63:0] result_p0;
  logic               overflow_p0;
  logic               zero_p0;
  logic signed [63:0] result_p1;
  logic               zero_p1;
  logic               overflow_p1;

  assign a_s     = bus.A;
  assign b_s     = bus.B;
  assign shamt   = bus.B[5:0];
  assign sum_p0  = a_s + b_s;
  assign diff_p0 = a_s - b_s;

  // Stage p0: combinational operation select; undefined codes yield zero.
  always_comb begin
    result_p0   = '0;
    overflow_p0 = 1'b0;
    unique case (bus.ALUop)
      OP_AND:  result_p0 = a_s & b_s;
      OP_OR:   result_p0 = a_s | b_s;
      OP_ADD: begin
        result_p0   = sum_p0;
        overflow_p0 = ovf_add(a_s, b_s, sum_p0);
      end
      OP_XOR:  result_p0 = a_s ^ b_s;
      OP_SLL:  result_p0 = a_s << shamt;
      OP_SRL:  result_p0 = $signed(bus.A >> shamt);
      OP_SUB: begin
        result_p0   = diff_p0;
        overflow_p0 = ovf_sub(a_s, b_s, diff_p0);
      end
      OP_SLT:  result_p0 = {63'd0, (a_s < b_s)};
      OP_SLTU: result_p0 = {63'd0, (bus.A < bus.B)};
      OP_SRA:  result_p0 = a_s >>> shamt;
      OP_NOR:  result_p0 = ~(a_s | b_s);
      default: begin
        result_p0   = '0;
        overflow_p0 = 1'b0;
      end
    endcase
  end

  assign zero_p0      = ~|result_p0;
  assign bus.result   = result_p0;
  assign bus.zero     = zero_p0;
  assign bus.overflow = overflow_p0;

  // Stage p0 -> p1: capture live result and flags every edge; reset clears at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p1   <= '0;
      zero_p1     <= 1'b1;
      overflow_p1 <= 1'b0;
    end else begin
      result_p1   <= result_p0;
      zero_p1     <= zero_p0;
      overflow_p1 <= overflow_p0;
    end
  end

  assign bus.result_q   = result_p1;
  assign bus.zero_q     = zero_p1;
  assign bus.overflow_q = overflow_p1;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vectors with hand-computed expectations, random
// vectors against a behavioural model, and the registered/reset path.
module tb_alu;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered outputs expected to be showing right now.
  logic [63:0] prev_res;
  logic        prev_zero;
  logic        prev_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain arithmetic on integers, overflow from a
  // 65-bit sign-extended sum leaving the 64-bit signed range.
  task automatic model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic ovf);
    logic [64:0] wide;
    int          sh;
    sh  = int'(b[5:0]);
    res = 64'd0;
    ovf = 1'b0;
    case (op)
      4'd0:  res = a & b;
      4'd1:  res = a | b;
      4'd2: begin
        wide = {a[63], a} + {b[63], b};
        res  = wide[63:0];
        ovf  = wide[64] != wide[63];
      end
      4'd3:  res = a ^ b;
      4'd4:  res = a << sh;
      4'd5:  res = a >> sh;
      4'd6: begin
        wide = {a[63], a} - {b[63], b};
        res  = wide[63:0];
        ovf  = wide[64] != wide[63];
      end
      4'd7:  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd8:  res = (a < b) ? 64'd1 : 64'd0;
      4'd9: begin
        res = a;
        for (int i = 0; i < sh; i++) res = {res[63], res[63:1]};
      end
      4'd12: res = ~(a | b);
      default: res = 64'd0;
    endcase
  endtask

  // Drive one operation, check combinational outputs and that the register
  // still holds the old value, then check the register after the edge.
  task automatic apply(input string tag, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input logic exp_ovf);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.ALUop = op;
    #1;
    check({tag, ".result"},   bus.result,          exp_res);
    check({tag, ".zero"},     64'(bus.zero),       64'(exp_res == 64'd0));
    check({tag, ".overflow"}, 64'(bus.overflow),   64'(exp_ovf));
    check({tag, ".hold_q"},   bus.result_q,        prev_res);
    check({tag, ".hold_zq"},  64'(bus.zero_q),     64'(prev_zero));
    @(posedge clk);
    #1;
    check({tag, ".result_q"},   bus.result_q,        exp_res);
    check({tag, ".zero_q"},     64'(bus.zero_q),     64'(exp_res == 64'd0));
    check({tag, ".overflow_q"}, 64'(bus.overflow_q), 64'(exp_ovf));
    prev_res  = exp_res;
    prev_zero = (exp_res == 64'd0);
    prev_ovf  = exp_ovf;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        ovf;
  } vec_t;

  vec_t dir[$];

  initial begin
    logic [63:0] mres;
    logic        movf;
    logic [63:0] ra, rb;
    logic [3:0]  rop;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.A     = 64'd0;
    bus.B     = 64'd0;
    bus.ALUop = 4'd0;
    prev_res  = 64'd0;
    prev_zero = 1'b1;
    prev_ovf  = 1'b0;

    #3;
    check("reset.result_q",   bus.result_q,        64'd0);
    check("reset.zero_q",     64'(bus.zero_q),     64'd1);
    check("reset.overflow_q", 64'(bus.overflow_q), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    dir = '{
      '{4'h0, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'h0, 1'b0},
      '{4'h1, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF, 1'b0},
      '{4'h3, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFFFFFFFFFF, 1'b0},
      '{4'hC, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'h0, 1'b0},
      '{4'h2, 64'd123, 64'd456, 64'd579, 1'b0},
      '{4'h6, 64'd1000, 64'd1, 64'd999, 1'b0},
      '{4'h2, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, 1'b1},
      '{4'h6, 64'd5, 64'd5, 64'd0, 1'b0},
      '{4'h6, 64'h8000000000000000, 64'd1, 64'h7FFFFFFFFFFFFFFF, 1'b1},
      '{4'h2, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b0},
      '{4'h7, 64'hFFFFFFFFFFFFFFFB, 64'd3, 64'd1, 1'b0},
      '{4'h7, 64'd3, 64'hFFFFFFFFFFFFFFFB, 64'd0, 1'b0},
      '{4'h8, 64'hFFFFFFFFFFFFFFFB, 64'd3, 64'd0, 1'b0},
      '{4'h7, 64'h8000000000000000, 64'd1, 64'd1, 1'b0},
      '{4'h4, 64'h8000000000000001, 64'h41, 64'h2, 1'b0},
      '{4'h5, 64'h8000000000000001, 64'd63, 64'd1, 1'b0},
      '{4'h9, 64'h8000000000000001, 64'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0},
      '{4'h4, 64'h8000000000000001, 64'd0, 64'h8000000000000001, 1'b0},
      '{4'h5, 64'h8000000000000001, 64'h40, 64'h8000000000000001, 1'b0},
      '{4'h9, 64'h8000000000000001, 64'd0, 64'h8000000000000001, 1'b0},
      '{4'h9, 64'h8000000000000000, 64'd4, 64'hF800000000000000, 1'b0},
      '{4'hF, 64'd123, 64'd456, 64'd0, 1'b0},
      '{4'hA, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b0},
      '{4'hD, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b0}
    };
    foreach (dir[i])
      apply($sformatf("dir%0d_op%0h", i, dir[i].op), dir[i].op, dir[i].a, dir[i].b,
            dir[i].res, dir[i].ovf);

    for (int n = 0; n < 300; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = {ra[63], 63'd0};
        1: rb = ra;
        2: rb = {$urandom, $urandom} & 64'h7F;
        3: ra = {~rb[63], ra[62:0]};
        default: ;
      endcase
      model(rop, ra, rb, mres, movf);
      apply($sformatf("rnd%0d_op%0h", n, rop), rop, ra, rb, mres, movf);
    end

    // Asynchronous reset mid-cycle after a nonzero capture.
    apply("pre_rst", 4'h2, 64'd9, 64'd1, 64'd10, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.result_q", bus.result_q,    64'd0);
    check("async_rst.zero_q",   64'(bus.zero_q), 64'd1);
    check("async_rst.comb",     bus.result,      64'd10);
    @(posedge clk);
    #1;
    check("rst_held.result_q", bus.result_q, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.A     = 64'd2;
    bus.B     = 64'd3;
    bus.ALUop = 4'h2;
    #1;
    check("post_rst.before_edge", bus.result_q, 64'd0);
    check("post_rst.comb",        bus.result,   64'd5);
    @(posedge clk);
    #1;
    check("post_rst.result_q", bus.result_q,    64'd5);
    check("post_rst.zero_q",   64'(bus.zero_q), 64'd0);
    #2;
    bus.A = 64'd40;
    #1;
    check("between_edges.result_q", bus.result_q, 64'd5);
    check("between_edges.comb",     bus.result,   64'd43);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
